// File: rtl/lvds_link_pkg.sv
// lvds_link_pkg: link-level constants shared by the LVDS transmit and receive sides.
// Holds frame-parser state encodings, K28.5 / header defaults, err_flags bit
// positions and the payload ramp pattern used for link bring-up.
package lvds_link_pkg;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_IDLE = 3'd1,
        ST_H1   = 3'd2,
        ST_PAY  = 3'd3,
        ST_END  = 3'd4
    } link_state_e;

    localparam logic [7:0] K28_5        = 8'hBC;
    localparam logic [7:0] HDR0_DEFAULT = 8'hEE;
    localparam logic [7:0] HDR1_DEFAULT = 8'h33;

    // err_flags layout: {pattern, length, header, code}
    localparam int ERR_CODE = 0;
    localparam int ERR_HDR  = 1;
    localparam int ERR_LEN  = 2;
    localparam int ERR_PAT  = 3;
    localparam int ERR_W    = 4;

    // Bring-up payload ramp: byte n of a frame carries (hdr1 + 1 + n) mod 256.
    function automatic logic [7:0] pattern_byte(input logic [7:0] hdr1, input logic [7:0] idx);
        return hdr1 + 8'd1 + idx;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    // Count increments, holding once the maximum value is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
        if (!rst_n) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lvds_rx_frame_checker.sv
// lvds_rx_frame_checker: locks onto the K28.5 idle stream from the 8b10b decoder,
// parses frames (idle, HDR0, HDR1, PAYLOAD_LEN data bytes, K28.5), forwards the
// payload and reports per-frame status plus saturating good/bad frame counts.
// Optional build macro: LVDS_PATTERN_CHECK_EN enables the payload ramp checker
// (err_flags[3]); when undefined that flag is tied low.
module lvds_rx_frame_checker
    import lvds_link_pkg::*;
#(
    parameter logic [7:0] COMMA       = K28_5,
    parameter logic [7:0] HDR0        = HDR0_DEFAULT,
    parameter logic [7:0] HDR1        = HDR1_DEFAULT,
    parameter int         PAYLOAD_LEN = 124,
    parameter int         LOCK_COMMAS = 4,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_k,
    input  logic             rx_valid,
    input  logic             rx_err,
    output logic             locked,
    output logic [7:0]       pl_data,
    output logic             pl_valid,
    output logic             pl_sof,
    output logic             pl_eof,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [ERR_W-1:0] err_flags,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam int BC_W  = $clog2(PAYLOAD_LEN + 1);
    localparam int RUN_W = $clog2(LOCK_COMMAS + 1);

    localparam logic [BC_W-1:0]  LAST_IDX = BC_W'(PAYLOAD_LEN - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COMMAS - 1);

    link_state_e      state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [BC_W-1:0]  cnt_q, cnt_d;

    logic             pl_valid_d, pl_sof_d, pl_eof_d;
    logic             done_d, ok_d;
    logic [ERR_W-1:0] flags_d;
    logic             pat_cur;      // pattern error already seen in the current frame
    logic             is_comma;
    logic             is_hdr0, is_hdr1;

    assign is_comma = rx_k && (rx_data == COMMA) && !rx_err;
    assign is_hdr0  = !rx_k && (rx_data == HDR0);
    assign is_hdr1  = !rx_k && (rx_data == HDR1);

    // Next-state, payload strobes and frame status for the byte accepted this cycle.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        run_d      = run_q;
        cnt_d      = cnt_q;
        pl_valid_d = 1'b0;
        pl_sof_d   = 1'b0;
        pl_eof_d   = 1'b0;
        done_d     = 1'b0;
        flags_d    = '0;

        if (rx_valid) begin
            if ((state_q != ST_HUNT) && rx_err) begin
                // A decoder error drops lock; IDLE has no frame in flight to report.
                flags_d[ERR_CODE] = 1'b1;
                done_d            = (state_q != ST_IDLE);
                state_d           = ST_HUNT;
                run_d             = '0;
            end else begin
                unique case (state_q)
                    ST_HUNT: begin
                        if (!is_comma) begin
                            run_d = '0;
                        end else if (run_q == RUN_LAST) begin
                            run_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end
                    ST_IDLE: begin
                        if (is_hdr0) begin
                            state_d = ST_H1;
                        end else if (!is_comma) begin
                            flags_d[ERR_HDR] = 1'b1;
                            done_d           = 1'b1;
                            state_d          = ST_HUNT;
                        end
                    end
                    ST_H1: begin
                        if (is_hdr1) begin
                            cnt_d   = '0;
                            state_d = ST_PAY;
                        end else begin
                            flags_d[ERR_HDR] = 1'b1;
                            done_d           = 1'b1;
                            state_d          = is_comma ? ST_IDLE : ST_HUNT;
                        end
                    end
                    ST_PAY: begin
                        if (!rx_k) begin
                            pl_valid_d = 1'b1;
                            pl_sof_d   = (cnt_q == '0);
                            pl_eof_d   = (cnt_q == LAST_IDX);
                            cnt_d      = cnt_q + BC_W'(1);
                            if (pl_eof_d) begin
                                state_d = ST_END;
                            end
                        end else begin
                            // Any K-char inside the payload means a short frame.
                            flags_d[ERR_LEN] = 1'b1;
                            done_d           = 1'b1;
                            state_d          = is_comma ? ST_IDLE : ST_HUNT;
                        end
                    end
                    ST_END: begin
                        done_d = 1'b1;
                        if (is_comma) begin
                            state_d = ST_IDLE;
                        end else begin
                            flags_d[ERR_LEN] = 1'b1;
                            state_d          = ST_HUNT;
                        end
                    end
                    default: begin
                        state_d = ST_HUNT;
                        run_d   = '0;
                    end
                endcase
            end

            if (done_d) begin
                flags_d[ERR_PAT] = pat_cur;
            end
        end

        ok_d = done_d && (flags_d == '0);
    end

`ifdef LVDS_PATTERN_CHECK_EN
    logic pat_q;

    // Sticky ramp-mismatch flag, cleared when a new payload starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= 1'b0;
        end else if (rx_valid && (state_q == ST_H1) && (state_d == ST_PAY)) begin
            pat_q <= 1'b0;
        end else if (pl_valid_d && (rx_data != pattern_byte(HDR1, 8'(cnt_q)))) begin
            pat_q <= 1'b1;
        end
    end

    assign pat_cur = pat_q && ((state_q == ST_PAY) || (state_q == ST_END));
`else
    assign pat_cur = 1'b0;
`endif

    // Parser state, comma run length and payload byte index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
            run_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs: payload stream, frame status pulse and lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked     <= 1'b0;
            pl_data    <= '0;
            pl_valid   <= 1'b0;
            pl_sof     <= 1'b0;
            pl_eof     <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_flags  <= '0;
        end else begin
            locked     <= (state_d != ST_HUNT);
            pl_valid   <= pl_valid_d;
            pl_sof     <= pl_sof_d;
            pl_eof     <= pl_eof_d;
            frame_done <= done_d;
            frame_ok   <= ok_d;
            err_flags  <= flags_d;
            if (pl_valid_d) begin
                pl_data <= rx_data;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_good_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (done_d && ok_d),
        .q     (good_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bad_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (done_d && !ok_d),
        .q     (bad_cnt)
    );

endmodule

// File: tb/tb_lvds_rx_frame_checker.sv
// tb_lvds_rx_frame_checker: directed + randomized frames against a frame-level
// expectation model (expected payload stream, frame results, lock and counters).
// A second small instance (2-byte payload, 3-bit counters) exercises saturation.
module tb_lvds_rx_frame_checker;

    localparam int         PLEN = 124;
    localparam logic [7:0] BC   = 8'hBC;
    localparam logic [7:0] H0   = 8'hEE;
    localparam logic [7:0] H1   = 8'h33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_k = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;

    logic        locked, pl_valid, pl_sof, pl_eof, frame_done, frame_ok;
    logic [7:0]  pl_data;
    logic [3:0]  err_flags;
    logic [15:0] good_cnt, bad_cnt;

    logic        s_locked, s_pl_valid, s_pl_sof, s_pl_eof, s_frame_done, s_frame_ok;
    logic [7:0]  s_pl_data;
    logic [3:0]  s_err_flags;
    logic [2:0]  s_good_cnt, s_bad_cnt;

    lvds_rx_frame_checker dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_k(rx_k),
        .rx_valid(rx_valid), .rx_err(rx_err), .locked(locked),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_sof(pl_sof), .pl_eof(pl_eof),
        .frame_done(frame_done), .frame_ok(frame_ok), .err_flags(err_flags),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    lvds_rx_frame_checker #(.PAYLOAD_LEN(2), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_k(rx_k),
        .rx_valid(rx_valid), .rx_err(rx_err), .locked(s_locked),
        .pl_data(s_pl_data), .pl_valid(s_pl_valid), .pl_sof(s_pl_sof), .pl_eof(s_pl_eof),
        .frame_done(s_frame_done), .frame_ok(s_frame_ok), .err_flags(s_err_flags),
        .good_cnt(s_good_cnt), .bad_cnt(s_bad_cnt)
    );

    always #5 clk = ~clk;

    // Observed streams, captured away from the active edge.
    logic [9:0] got_pl[$];
    logic [4:0] got_fr[$];

    always @(negedge clk) begin
        if (pl_valid)   got_pl.push_back({pl_sof, pl_eof, pl_data});
        if (frame_done) got_fr.push_back({frame_ok, err_flags});
    end

    // Expectation model state.
    logic [9:0] exp_pl[$];
    logic [4:0] exp_fr[$];
    int         exp_good = 0;
    int         exp_bad  = 0;
    logic       exp_locked = 1'b0;
    int         exp_run  = 0;
    bit         stall_en = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] pat(input int n);
        return 8'((32'h33 + 1 + n) % 256);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            rx_k     = 1'($urandom);
            rx_err   = 1'($urandom);
        end
    endtask

    // One accepted byte, optionally preceded by random stall cycles carrying junk.
    task automatic put(input logic k, input logic [7:0] d, input logic e);
        int cap = 0;
        while (stall_en && (($urandom % 2) == 1) && (cap < 4)) begin
            idle(1);
            cap++;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_k     = k;
        rx_data  = d;
        rx_err   = e;
        if (!exp_locked) begin
            if (k && (d == BC) && !e) begin
                exp_run++;
                if (exp_run == 4) begin
                    exp_locked = 1'b1;
                    exp_run    = 0;
                end
            end else begin
                exp_run = 0;
            end
        end
    endtask

    task automatic comma(input int n);
        for (int i = 0; i < n; i++) put(1'b1, BC, 1'b0);
    endtask

    task automatic pay_byte(input int n, input logic [7:0] d);
        put(1'b0, d, 1'b0);
        exp_pl.push_back({(n == 0), (n == PLEN - 1), d});
    endtask

    task automatic result(input logic ok, input logic [3:0] flags);
        exp_fr.push_back({ok, flags});
        if (ok) exp_good++;
        else    exp_bad++;
    endtask

    task automatic lose_lock();
        exp_locked = 1'b0;
        exp_run    = 0;
    endtask

    task automatic header();
        put(1'b0, H0, 1'b0);
        put(1'b0, H1, 1'b0);
    endtask

    // kind: 0 good, 1 short, 2 long, 3 code error, 4 bad HDR1, 5 foreign K-char, 6 pattern
    task automatic run_frame(input int kind, input int pos);
        case (kind)
            0: begin
                header();
                for (int n = 0; n < PLEN; n++) pay_byte(n, pat(n));
                comma(1);
                result(1'b1, 4'b0000);
            end
            1: begin
                header();
                for (int n = 0; n < pos; n++) pay_byte(n, pat(n));
                comma(1);
                result(1'b0, 4'b0100);
            end
            2: begin
                header();
                for (int n = 0; n < PLEN; n++) pay_byte(n, pat(n));
                put(1'b0, pat(PLEN), 1'b0);
                result(1'b0, 4'b0100);
                lose_lock();
            end
            3: begin
                header();
                for (int n = 0; n < pos; n++) pay_byte(n, pat(n));
                put(1'b0, pat(pos), 1'b1);
                result(1'b0, 4'b0001);
                lose_lock();
            end
            4: begin
                put(1'b0, H0, 1'b0);
                put(1'b0, 8'h34, 1'b0);
                result(1'b0, 4'b0010);
                lose_lock();
            end
            5: begin
                header();
                for (int n = 0; n < pos; n++) pay_byte(n, pat(n));
                put(1'b1, 8'h1C, 1'b0);
                result(1'b0, 4'b0100);
                lose_lock();
            end
            default: begin
                header();
                for (int n = 0; n < PLEN; n++) pay_byte(n, (n == pos) ? 8'h00 : pat(n));
                comma(1);
`ifdef LVDS_PATTERN_CHECK_EN
                result(1'b0, 4'b1000);
`else
                result(1'b1, 4'b0000);
`endif
            end
        endcase
    endtask

    task automatic verify(input string tag);
        idle(3);
        check({tag, " pl_count"}, got_pl.size(), exp_pl.size());
        for (int i = 0; (i < got_pl.size()) && (i < exp_pl.size()); i++)
            check($sformatf("%s pl[%0d]", tag, i), got_pl[i], exp_pl[i]);
        check({tag, " frame_count"}, got_fr.size(), exp_fr.size());
        for (int i = 0; (i < got_fr.size()) && (i < exp_fr.size()); i++)
            check($sformatf("%s frame[%0d] {ok,flags}", tag, i), got_fr[i], exp_fr[i]);
        check({tag, " locked"}, locked, exp_locked);
        check({tag, " good_cnt"}, good_cnt, exp_good);
        check({tag, " bad_cnt"}, bad_cnt, exp_bad);
        got_pl.delete();
        got_fr.delete();
        exp_pl.delete();
        exp_fr.delete();
    endtask

    initial begin
        // Reset state.
        idle(3);
        rst_n = 1'b1;
        idle(1);
        check("rst locked", locked, 0);
        check("rst pl_valid", pl_valid, 0);
        check("rst pl_data", pl_data, 0);
        check("rst frame_done", frame_done, 0);
        check("rst frame_ok", frame_ok, 0);
        check("rst err_flags", err_flags, 0);
        check("rst good_cnt", good_cnt, 0);
        check("rst bad_cnt", bad_cnt, 0);

        // Lock after exactly the 4th comma, then a good frame.
        comma(3);
        idle(1);
        check("lock after 3 commas", locked, 0);
        comma(1);
        idle(1);
        check("lock after 4 commas", locked, 1);
        comma(6);
        run_frame(0, 0);
        verify("good");

        // Short frame, then a good frame without relocking.
        run_frame(1, 100);
        run_frame(0, 0);
        verify("short");

        // Long frame loses lock; four commas relock.
        run_frame(2, 0);
        verify("long");
        comma(4);
        run_frame(0, 0);
        verify("relock");

        // Code error on payload byte 50; a header byte before lock is ignored.
        run_frame(3, 50);
        put(1'b0, H0, 1'b0);
        comma(4);
        run_frame(0, 0);
        verify("code_err");

        // Bad HDR1, junk in IDLE, comma in H1, decoder error in IDLE.
        run_frame(4, 0);
        comma(4);
        put(1'b0, 8'h55, 1'b0);
        result(1'b0, 4'b0010);
        lose_lock();
        comma(4);
        put(1'b0, H0, 1'b0);
        put(1'b1, BC, 1'b0);
        result(1'b0, 4'b0010);
        put(1'b1, BC, 1'b1);
        lose_lock();
        verify("header");

        // Good frame with random stalls carrying junk.
        comma(4);
        stall_en = 1'b1;
        run_frame(0, 0);
        stall_en = 1'b0;
        verify("stall");

        // Ramp violation on byte 10.
        run_frame(6, 10);
        verify("pattern");

        // Randomized frame mix.
        for (int it = 0; it < 12; it++) begin
            int kind = int'($urandom_range(6, 0));
            int pos  = int'($urandom_range(PLEN - 1, 1));
            stall_en = 1'($urandom);
            if (!exp_locked) comma(int'($urandom_range(6, 4)));
            else             comma(int'($urandom_range(3, 0)));
            run_frame(kind, pos);
            verify($sformatf("rand%0d k%0d", it, kind));
        end
        stall_en = 1'b0;

        // Async reset mid-frame discards the frame.
        if (!exp_locked) comma(4);
        header();
        for (int n = 0; n < 20; n++) put(1'b0, pat(n), 1'b0);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst locked", locked, 0);
        check("midrst pl_valid", pl_valid, 0);
        check("midrst good_cnt", good_cnt, 0);
        check("midrst bad_cnt", bad_cnt, 0);
        idle(2);
        rst_n = 1'b1;
        got_pl.delete();
        got_fr.delete();
        exp_pl.delete();
        exp_fr.delete();
        exp_good = 0;
        exp_bad  = 0;
        lose_lock();
        for (int n = 20; n < PLEN; n++) put(1'b0, pat(n), 1'b0);
        comma(1);
        verify("post_reset");

        // Saturation on the 3-bit counter instance.
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        comma(4);
        for (int f = 1; f <= 9; f++) begin
            put(1'b0, H0, 1'b0);
            put(1'b0, H1, 1'b0);
            put(1'b0, 8'h34, 1'b0);
            put(1'b0, 8'h35, 1'b0);
            put(1'b1, BC, 1'b0);
            idle(2);
            if (f == 6) check("sat good_cnt at 6", s_good_cnt, 6);
            if (f == 7) check("sat good_cnt at 7", s_good_cnt, 7);
        end
        check("sat good_cnt held", s_good_cnt, 7);
        check("sat bad_cnt", s_bad_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
